// File: rtl/dlx_pkg.sv
// Shared DLX integer-pipeline definitions: datapath widths, register index type and r0.
package dlx_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t R0 = 5'd0;

endpackage : dlx_pkg

// File: rtl/regs_if.sv
// Register-file bus: write-back port from WB stage plus the two decode-stage read ports.
interface regs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic              WB;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] reg_s;
  logic [ADDR_W-1:0] Rs1;
  logic [ADDR_W-1:0] Rs2;
  logic [DATA_W-1:0] S1;
  logic [DATA_W-1:0] S2;

  modport master (
    output WB,
    output Rd,
    output reg_s,
    output Rs1,
    output Rs2,
    input  S1,
    input  S2
  );

  modport slave (
    input  WB,
    input  Rd,
    input  reg_s,
    input  Rs1,
    input  Rs2,
    output S1,
    output S2
  );

endinterface : regs_if

// File: rtl/regs_read_port.sv
// One combinational register-file read port: r0 reads zero, then write-back bypass, then array.
module regs_read_port
  import dlx_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]                   idx_i,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    mem_i,
  input  logic                                wb_i,
  input  logic [ADDR_W-1:0]                   rd_i,
  input  logic [DATA_W-1:0]                   wdata_i,
  output logic [DATA_W-1:0]                   rdata_o
);

  logic is_r0;
  logic hit_wb;

  assign is_r0  = (idx_i == ADDR_W'(R0));
  // idx is known non-zero when this matters, so rd != r0 is implied.
  assign hit_wb = wb_i && (rd_i == idx_i);

  always_comb begin
    rdata_o = mem_i[idx_i];
    if (is_r0) begin
      rdata_o = '0;
    end else if (hit_wb) begin
      rdata_o = wdata_i;
    end
  end

endmodule : regs_read_port

// File: rtl/regs.sv
// DLX general-purpose register file: 32 x 32-bit, one write port, two bypassed read ports.
module regs
  import dlx_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  regs_if.slave  rf_if
);

  localparam int unsigned NumRegs = 2**ADDR_W;

  logic [NumRegs-1:0][DATA_W-1:0] mem_q;
  logic [NumRegs-1:0][DATA_W-1:0] mem_d;
  logic                           wr_en;

  assign wr_en = rf_if.WB && (rf_if.Rd != ADDR_W'(R0));

  // Entry 0 is never written, so it stays zero from reset onward.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[rf_if.Rd] = rf_if.reg_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regs_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_s1 (
    .idx_i   (rf_if.Rs1),
    .mem_i   (mem_q),
    .wb_i    (rf_if.WB),
    .rd_i    (rf_if.Rd),
    .wdata_i (rf_if.reg_s),
    .rdata_o (rf_if.S1)
  );

  regs_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_s2 (
    .idx_i   (rf_if.Rs2),
    .mem_i   (mem_q),
    .wb_i    (rf_if.WB),
    .rd_i    (rf_if.Rd),
    .wdata_i (rf_if.reg_s),
    .rdata_o (rf_if.S2)
  );

endmodule : regs

// File: tb/tb_regs.sv
// Directed-vector bench for the DLX register file.
module tb_regs;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  regs_if #(.DATA_W(32), .ADDR_W(5)) rf_if ();

  regs #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf_if (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    rf_if.WB    = 1'b0;
    rf_if.Rd    = '0;
    rf_if.reg_s = '0;
    rf_if.Rs1   = 5'd1;
    rf_if.Rs2   = 5'd24;

    // Reset
    tick();
    tick();
    #1;
    check("rst_s1", rf_if.S1, 32'd0);
    check("rst_s2", rf_if.S2, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_s1", rf_if.S1, 32'd0);
    check("post_rst_s2", rf_if.S2, 32'd0);

    // Basic write / hold
    rf_if.WB = 1'b1; rf_if.Rd = 5'd7; rf_if.reg_s = 32'd111111;
    tick();
    rf_if.WB = 1'b0; rf_if.Rs1 = 5'd7;
    #1;
    check("wr7", rf_if.S1, 32'd111111);
    rf_if.reg_s = 32'd222222;
    tick(); tick(); tick();
    check("hold7", rf_if.S1, 32'd111111);

    // Sequential writes to r1
    rf_if.Rs1 = 5'd1; rf_if.Rs2 = 5'd24; rf_if.Rd = 5'd1;
    for (int i = 1; i <= 9; i++) begin
      rf_if.WB = 1'b1; rf_if.reg_s = 32'(111111 * i);
      tick();
      rf_if.WB = 1'b0;
      #1;
      check($sformatf("seq%0d_s1", i), rf_if.S1, 32'(111111 * i));
      check($sformatf("seq%0d_s2", i), rf_if.S2, 32'd0);
    end

    // r0 write is discarded, r0 reads zero even with matching bypass
    rf_if.WB = 1'b1; rf_if.Rd = 5'd0; rf_if.reg_s = 32'hDEADBEEF;
    rf_if.Rs1 = 5'd0; rf_if.Rs2 = 5'd0;
    #1;
    check("r0_byp_s1", rf_if.S1, 32'd0);
    check("r0_byp_s2", rf_if.S2, 32'd0);
    tick();
    rf_if.WB = 1'b0;
    #1;
    check("r0_s1", rf_if.S1, 32'd0);
    check("r0_s2", rf_if.S2, 32'd0);

    // Bypass on both ports
    rf_if.WB = 1'b1; rf_if.Rd = 5'd5; rf_if.reg_s = 32'd10;
    tick();
    rf_if.WB = 1'b0; rf_if.reg_s = 32'd20; rf_if.Rs1 = 5'd5; rf_if.Rs2 = 5'd5;
    #1;
    check("pre_byp_s1", rf_if.S1, 32'd10);
    check("pre_byp_s2", rf_if.S2, 32'd10);
    rf_if.WB = 1'b1;
    #1;
    check("byp_s1", rf_if.S1, 32'd20);
    check("byp_s2", rf_if.S2, 32'd20);
    tick();
    rf_if.WB = 1'b0;
    #1;
    check("after_byp_s1", rf_if.S1, 32'd20);
    check("after_byp_s2", rf_if.S2, 32'd20);

    // Full sweep
    for (int k = 1; k < 32; k++) begin
      rf_if.WB = 1'b1; rf_if.Rd = 5'(k); rf_if.reg_s = 32'(3 * k);
      tick();
    end
    rf_if.WB = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rf_if.Rs1 = 5'(k); rf_if.Rs2 = 5'(31 - k);
      #1;
      check($sformatf("sweep_s1_r%0d", k), rf_if.S1, 32'(3 * k));
      check($sformatf("sweep_s2_r%0d", 31 - k), rf_if.S2, 32'(3 * (31 - k)));
    end

    // Asynchronous reset mid-cycle, with a write pending across the edge
    rf_if.Rs1 = 5'd31; rf_if.Rs2 = 5'd9;
    #1;
    check("pre_arst_s1", rf_if.S1, 32'd93);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_s1", rf_if.S1, 32'd0);
    check("arst_s2", rf_if.S2, 32'd0);
    rf_if.WB = 1'b1; rf_if.Rd = 5'd9; rf_if.reg_s = 32'd77;
    tick();
    rf_if.WB = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_wins_r9", rf_if.S2, 32'd0);
    check("rst_clr_r31", rf_if.S1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regs
